// File: rtl/ahbl_rr_master_arbiter_pkg.sv
// ahbl_arb_pkg: shared AHB-Lite encodings and FSM state type for the round-robin master arbiter
package ahbl_arb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} arb_state_t;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        return (s > HSIZE_WORD) ? HSIZE_WORD : s;
    endfunction
endpackage

// File: rtl/ahbl_rr_master_arbiter_pick.sv
// ahbl_rr_pick: combinational round-robin picker, first set request searching upward from ptr+1
// Ports: req (request vector), ptr (last winner), valid (any request), idx (winner index)
module ahbl_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic            valid,
    output logic [2:0]      idx
);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [3:0]        base;
    logic [3:0]        pos;
    // Rotating a doubled copy puts requester ptr+1 at bit 0; the lowest set bit wins.
    always_comb begin
        dbl   = {req, req};
        base  = {1'b0, ptr} + 4'd1;
        rot   = NREQ'(dbl >> base);
        valid = |rot;
        pos   = '0;
        for (int j = NREQ - 1; j >= 0; j--) pos = rot[j] ? base + 4'(j) : pos;
        idx   = 3'((pos >= 4'(NREQ)) ? pos - 4'(NREQ) : pos);
    end
endmodule

// File: rtl/ahbl_rr_master_arbiter.sv
// ahbl_rr_master_arbiter: round-robin sharing of one AHB-Lite master port among NREQ req/ack requesters
// Ports: HCLK/HRESETN clock and async active-low reset; REQ* packed per-requester commands;
//        ACK/RSP_* completion pulse and response; GRANT_ID/BUSY status; H* AHB-Lite master signals.
module ahbl_rr_master_arbiter
    import ahbl_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic               HCLK,
    input  logic               HRESETN,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ-1:0]    REQ_WRITE,
    input  logic [NREQ*32-1:0] REQ_ADDR,
    input  logic [NREQ*3-1:0]  REQ_SIZE,
    input  logic [NREQ*32-1:0] REQ_WDATA,
    output logic [NREQ-1:0]    ACK,
    output logic [31:0]        RSP_RDATA,
    output logic               RSP_ERR,
    output logic               RSP_TIMEOUT,
    output logic [2:0]         GRANT_ID,
    output logic               BUSY,
    output logic [31:0]        HADDR,
    output logic [1:0]         HTRANS,
    output logic               HWRITE,
    output logic [2:0]         HSIZE,
    output logic [2:0]         HBURST,
    output logic [3:0]         HPROT,
    output logic               HMASTLOCK,
    output logic [31:0]        HWDATA,
    input  logic [31:0]        HRDATA,
    input  logic               HREADY,
    input  logic               HRESP
);
    arb_state_t  state;
    logic [31:0] wdata_q;
    logic [15:0] wait_cnt;
    logic        pick_valid;
    logic [2:0]  pick_idx;
    logic        timeout_hit;
    logic [31:0] addr_a  [8];
    logic [31:0] wdata_a [8];
    logic [2:0]  size_a  [8];
    logic        write_a [8];
    // Lanes padded to 8 so a 3-bit index always lands inside the arrays.
    for (genvar i = 0; i < 8; i++) begin : g_lane
        if (i < NREQ) begin : g_on
            assign addr_a[i]  = REQ_ADDR[32*i +: 32];
            assign wdata_a[i] = REQ_WDATA[32*i +: 32];
            assign size_a[i]  = REQ_SIZE[3*i +: 3];
            assign write_a[i] = REQ_WRITE[i];
        end else begin : g_off
            assign addr_a[i]  = '0;
            assign wdata_a[i] = '0;
            assign size_a[i]  = '0;
            assign write_a[i] = 1'b0;
        end
    end
    ahbl_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (REQ),
        .ptr   (GRANT_ID),
        .valid (pick_valid),
        .idx   (pick_idx)
    );
    assign HBURST      = HBURST_SINGLE;
    assign HPROT       = HPROT_DEFAULT;
    assign HMASTLOCK   = 1'b0;
    assign timeout_hit = (TIMEOUT_CYC != 0) && !HREADY && (wait_cnt + 16'd1 == 16'(TIMEOUT_CYC));
    // GRANT_ID doubles as the round-robin pointer: both track the last winner.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state       <= ST_IDLE;
            GRANT_ID    <= 3'(NREQ - 1);
            BUSY        <= 1'b0;
            wdata_q     <= '0;
            wait_cnt    <= '0;
            HTRANS      <= HTRANS_IDLE;
            HADDR       <= '0;
            HWRITE      <= 1'b0;
            HSIZE       <= HSIZE_WORD;
            HWDATA      <= '0;
            ACK         <= '0;
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
        end else begin
            ACK <= '0;
            case (state)
                ST_IDLE: begin
                    // A completion cycle blocks arbitration, forcing a gap between grants.
                    if (!(|ACK) && pick_valid) begin
                        state    <= ST_ADDR;
                        BUSY     <= 1'b1;
                        GRANT_ID <= pick_idx;
                        HTRANS   <= HTRANS_NONSEQ;
                        HADDR    <= addr_a[pick_idx];
                        HWRITE   <= write_a[pick_idx];
                        HSIZE    <= clamp_size(size_a[pick_idx]);
                        wdata_q  <= wdata_a[pick_idx];
                        wait_cnt <= '0;
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (HREADY) begin
                        wait_cnt <= '0;
                        if (state == ST_ADDR) begin
                            state  <= ST_DATA;
                            HTRANS <= HTRANS_IDLE;
                            HWDATA <= HWRITE ? wdata_q : '0;
                        end else begin
                            state       <= ST_IDLE;
                            BUSY        <= 1'b0;
                            ACK         <= NREQ'(1) << GRANT_ID;
                            RSP_RDATA   <= HWRITE ? RSP_RDATA : HRDATA;
                            RSP_ERR     <= HRESP;
                            RSP_TIMEOUT <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state       <= ST_IDLE;
                        BUSY        <= 1'b0;
                        HTRANS      <= HTRANS_IDLE;
                        ACK         <= NREQ'(1) << GRANT_ID;
                        RSP_RDATA   <= '0;
                        RSP_ERR     <= 1'b1;
                        RSP_TIMEOUT <= 1'b1;
                        wait_cnt    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahbl_rr_master_arbiter.sv
// tb_ahbl_rr_master_arbiter: randomized scoreboard bench for the round-robin AHB-Lite master arbiter
module tb_ahbl_rr_master_arbiter;
    localparam int NREQ = 4;
    localparam int TO   = 8;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        bit          err;
        bit          to;
        int          at;
    } exp_t;

    logic               HCLK = 1'b0;
    logic               HRESETN;
    logic [NREQ-1:0]    REQ;
    logic [NREQ-1:0]    REQ_WRITE;
    logic [NREQ*32-1:0] REQ_ADDR;
    logic [NREQ*3-1:0]  REQ_SIZE;
    logic [NREQ*32-1:0] REQ_WDATA;
    logic [NREQ-1:0]    ACK;
    logic [31:0]        RSP_RDATA;
    logic               RSP_ERR;
    logic               RSP_TIMEOUT;
    logic [2:0]         GRANT_ID;
    logic               BUSY;
    logic [31:0]        HADDR;
    logic [1:0]         HTRANS;
    logic               HWRITE;
    logic [2:0]         HSIZE;
    logic [2:0]         HBURST;
    logic [3:0]         HPROT;
    logic               HMASTLOCK;
    logic [31:0]        HWDATA;
    logic [31:0]        HRDATA;
    logic               HREADY;
    logic               HRESP;

    logic        r_write [NREQ];
    logic [31:0] r_addr  [NREQ];
    logic [2:0]  r_size  [NREQ];
    logic [31:0] r_wdata [NREQ];
    int          cfg_waits [NREQ];
    bit          cfg_err   [NREQ];
    logic [31:0] cfg_rdata [NREQ];
    int          want [NREQ];
    bit          hang;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          last_g = NREQ - 1;
    logic [31:0] last_rdata = '0;
    exp_t        sb[$];

    ahbl_rr_master_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .REQ(REQ), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
        .REQ_SIZE(REQ_SIZE), .REQ_WDATA(REQ_WDATA), .ACK(ACK), .RSP_RDATA(RSP_RDATA),
        .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT), .GRANT_ID(GRANT_ID), .BUSY(BUSY),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            REQ_WRITE[i]         = r_write[i];
            REQ_ADDR[32*i +: 32] = r_addr[i];
            REQ_SIZE[3*i +: 3]   = r_size[i];
            REQ_WDATA[32*i +: 32] = r_wdata[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_htrans"}, 32'(HTRANS), 32'd0);
        chk({nm, "_haddr"}, HADDR, 32'd0);
        chk({nm, "_hwrite"}, 32'(HWRITE), 32'd0);
        chk({nm, "_hsize"}, 32'(HSIZE), 32'd2);
        chk({nm, "_hwdata"}, HWDATA, 32'd0);
        chk({nm, "_ack"}, 32'(ACK), 32'd0);
        chk({nm, "_rdata"}, RSP_RDATA, 32'd0);
        chk({nm, "_err"}, 32'(RSP_ERR), 32'd0);
        chk({nm, "_tmo"}, 32'(RSP_TIMEOUT), 32'd0);
        chk({nm, "_gid"}, 32'(GRANT_ID), 32'(NREQ - 1));
        chk({nm, "_busy"}, 32'(BUSY), 32'd0);
    endtask

    task automatic setreq(input int i, input logic w, input logic [31:0] a, input logic [2:0] s,
                          input logic [31:0] d, input int waits, input bit er, input logic [31:0] rd);
        r_write[i] = w; r_addr[i] = a; r_size[i] = s; r_wdata[i] = d;
        cfg_waits[i] = waits; cfg_err[i] = er; cfg_rdata[i] = rd;
    endtask

    // Reference: each grant goes to the next requester after the previous winner that still
    // has transfers outstanding; responses follow from the slave configuration.
    task automatic run_batch(input int lat);
        int   left[NREQ];
        int   p, g, t0, n, budget;
        bit   found, any;
        exp_t e;
        @(negedge HCLK);
        t0 = cyc;
        left = want;
        p = last_g;
        n = 0;
        forever begin
            found = 0;
            g = 0;
            for (int k = NREQ; k >= 1; k--) if (left[(p + k) % NREQ] > 0) begin g = (p + k) % NREQ; found = 1; end
            if (!found) break;
            e.id = g;
            e.at = -1;
            if (hang) begin
                e.err = 1; e.to = 1; e.rdata = 0;
            end else begin
                e.err = cfg_err[g]; e.to = 0;
                e.rdata = r_write[g] ? last_rdata : cfg_rdata[g];
            end
            last_rdata = e.rdata;
            sb.push_back(e);
            left[g]--;
            p = g;
            n++;
        end
        last_g = p;
        if (n == 1 && lat >= 0) sb[sb.size() - 1].at = t0 + lat;
        left = want;
        for (int i = 0; i < NREQ; i++) REQ[i] = (want[i] > 0);
        budget = 0;
        forever begin
            any = 0;
            for (int i = 0; i < NREQ; i++) any |= (left[i] != 0);
            if (!any) break;
            if (budget++ > 400) begin
                total++; bad++;
                $display("FAIL batch_budget actual=%0d_acks_missing required=0", sb.size());
                REQ = '0;
                sb.delete();
                break;
            end
            @(negedge HCLK);
            for (int i = 0; i < NREQ; i++) if (ACK[i] && left[i] > 0) begin
                left[i]--;
                if (left[i] == 0) REQ[i] = 1'b0;
            end
        end
    endtask

    // Slave: one wait per configured cycle, two-cycle HRESP on error, stalls forever when hang is set.
    initial begin
        int          wl;
        bit          ind, er;
        logic [31:0] rd;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        ind = 0; wl = 0; er = 0; rd = '0;
        forever begin
            @(negedge HCLK);
            if (!HRESETN) begin
                ind = 0; HREADY = 1'b1; HRESP = 1'b0;
            end else if (ind) begin
                if (wl > 0) begin
                    HREADY = 1'b0; HRESP = er && (wl == 1); HRDATA = $urandom; wl--;
                end else begin
                    HREADY = 1'b1; HRESP = er; HRDATA = rd; ind = 0;
                end
            end else begin
                HREADY = !hang; HRESP = 1'b0;
                if (HTRANS == 2'b10 && !hang && int'(GRANT_ID) < NREQ) begin
                    ind = 1; wl = cfg_waits[GRANT_ID]; er = cfg_err[GRANT_ID]; rd = cfg_rdata[GRANT_ID];
                end
            end
        end
    end

    // Monitor: checks address phases and write data against the requester table and pops the
    // scoreboard on every ACK.
    initial begin
        bit          dphase;
        logic [31:0] dw;
        int          g;
        exp_t        e;
        dphase = 0; dw = '0;
        forever begin
            @(negedge HCLK);
            #1;
            if (!HRESETN) begin
                dphase = 0;
                continue;
            end
            if (dphase) begin
                chk("hwdata", HWDATA, dw);
                dphase = 0;
            end
            if (HTRANS == 2'b10) begin
                g = int'(GRANT_ID) % NREQ;
                chk("haddr", HADDR, r_addr[g]);
                chk("hwrite", 32'(HWRITE), 32'(r_write[g]));
                chk("hsize", 32'(HSIZE), (r_size[g] > 3'd2) ? 32'd2 : 32'(r_size[g]));
                chk("hburst_hprot_lock", {24'd0, HBURST, HPROT, HMASTLOCK}, {24'd0, 3'b000, 4'b0011, 1'b0});
                if (HREADY) begin
                    dphase = 1;
                    dw = r_write[g] ? r_wdata[g] : 32'd0;
                end
            end
            if (|ACK) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 32'(ACK), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_vec", 32'(ACK), 32'd1 << e.id);
                    chk("grant_id", 32'(GRANT_ID), 32'(e.id));
                    chk("rsp_rdata", RSP_RDATA, e.rdata);
                    chk("rsp_err", 32'(RSP_ERR), 32'(e.err));
                    chk("rsp_timeout", 32'(RSP_TIMEOUT), 32'(e.to));
                    chk("busy_at_ack", 32'(BUSY), 32'd0);
                    if (e.at >= 0) chk("ack_cycle", 32'(cyc), 32'(e.at));
                    if (e.to) chk("htrans_after_to", 32'(HTRANS), 32'd0);
                end
            end
        end
    end

    initial begin
        int n;
        bit er;
        HRESETN = 1'b0; REQ = '0; hang = 0;
        for (int i = 0; i < NREQ; i++) begin
            setreq(i, 1'b0, 32'd0, 3'd2, 32'd0, 0, 0, 32'd0);
            want[i] = 0;
        end
        repeat (3) @(negedge HCLK);
        check_reset("rst0");
        HRESETN = 1'b1;
        setreq(0, 1'b1, 32'h0000_0010, 3'd2, 32'hA5A5_A5A5, 0, 0, 32'd0);
        want = '{1, 0, 0, 0};
        run_batch(3);
        setreq(1, 1'b0, 32'h0000_0040, 3'd2, 32'd0, 3, 0, 32'h1234_5678);
        want = '{0, 1, 0, 0};
        run_batch(6);
        for (int i = 0; i < NREQ; i++)
            setreq(i, 1'(i % 2), 32'h100 + 32'(16 * i), 3'(i), 32'hC0DE_0000 + 32'(i), 0, 0, 32'hD00D_0000 + 32'(i));
        want = '{2, 1, 1, 1};
        run_batch(-1);
        setreq(3, 1'b0, 32'h0000_0080, 3'd1, 32'd0, 1, 1, 32'hBAD0_BAD0);
        want = '{0, 0, 0, 1};
        run_batch(4);
        repeat (10) begin
            for (int i = 0; i < NREQ; i++) begin
                er = ($urandom_range(0, 3) == 0);
                setreq(i, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 3'($urandom_range(0, 7)), $urandom,
                       er ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3)), er, $urandom);
                want[i] = int'($urandom_range(0, 2));
            end
            if (want[0] + want[1] + want[2] + want[3] == 0) want[0] = 1;
            run_batch(-1);
        end
        setreq(2, 1'b0, 32'h0000_0200, 3'd2, 32'd0, 0, 0, 32'd0);
        hang = 1;
        want = '{0, 0, 1, 0};
        run_batch(1 + TO);
        hang = 0;
        setreq(2, 1'b1, 32'h0000_0300, 3'd2, 32'hFEED_F00D, 5, 0, 32'd0);
        @(negedge HCLK);
        REQ[2] = 1'b1;
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (!(BUSY && HTRANS == 2'b00) && n < 20);
        chk("reach_data_phase", 32'(BUSY && HTRANS == 2'b00), 32'd1);
        #2 HRESETN = 1'b0;
        #1 check_reset("rst_mid");
        REQ = '0;
        last_g = NREQ - 1;
        last_rdata = '0;
        repeat (2) @(negedge HCLK);
        HRESETN = 1'b1;
        setreq(0, 1'b0, 32'h0000_0400, 3'd2, 32'd0, 0, 0, 32'h0BAD_CAFE);
        setreq(3, 1'b1, 32'h0000_0500, 3'd0, 32'h7777_7777, 1, 0, 32'd0);
        want = '{1, 0, 0, 1};
        run_batch(-1);
        repeat (4) @(negedge HCLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
